stepper_multi_ctrl: RTL and testbench
=====================================

# stepper_multi_ctrl

Multi-channel stepper-motor pulse generator. It replaces the fixed free-running STEP divider and the register-driven enable/direction lines with a command-driven engine. Each of NUM_CH channels accepts a move command (direction, step count, half-period) and produces direction-setup, enable and STEP pulses. It reports busy, done and steps remaining. It sits between processor-visible control registers and the JA motor-driver pins.

## Interface
- NUM_CH, 2: number of independent motor channels (≥1)
- CNT_W, 16: step-count width
- DIV_W, 18: half-period divider width, in clock cycles
- SETUP_CYC, 4: cycles motor_dir is held stable before the first STEP rising edge (≥1)
- CH_W, derived: max(1, $clog2(NUM_CH))

Ports:
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; all state cleared while low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_ch  in  CH_W  target channel
- cmd_dir  in  1  direction for the move
- cmd_steps  in  CNT_W  number of STEP pulses
- cmd_half  in  DIV_W  STEP high time and low time, in cycles; 0 treated as 1
- abort  in  NUM_CH  per-channel immediate stop
- motor_on  out  NUM_CH  driver enable
- motor_dir  out  NUM_CH  direction pin
- motor_step  out  NUM_CH  STEP pin
- busy  out  NUM_CH  channel executing a move
- done  out  NUM_CH  one-cycle pulse on normal completion
- steps_left  out  NUM_CH*CNT_W  remaining steps, channel k at [k*CNT_W +: CNT_W]

## Operation
- Reset values: all outputs 0, every channel IDLE, counters 0.
- cmd_ready = !busy[cmd_ch] & !abort[cmd_ch] & (cmd_ch < NUM_CH). It is combinational.
- Per-channel FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE to SETUP on accept. Latch dir, steps and half (half 0 becomes 1). Set steps_left to cmd_steps.
  - If cmd_steps == 0, the FSM stays IDLE, done pulses the next cycle, and motor_on stays 0.
  - SETUP to HIGH after SETUP_CYC cycles. motor_step = 0.
  - HIGH to LOW after half cycles. motor_step = 1.
  - LOW lasts half cycles. motor_step = 0. On leaving LOW, steps_left decrements. If the new value is ≠0, go to HIGH; if 0, go to IDLE and pulse done.
- busy = motor_on = (state != IDLE).
- motor_dir holds the last latched direction, including in IDLE. It changes only on accept.
- Abort in any non-IDLE state:
  - Next cycle the state is IDLE and motor_step = 0 (a HIGH phase is truncated).
  - No done pulse.
  - steps_left holds the un-decremented remaining count.
- Abort in IDLE has no effect.
- Channels are fully independent. Only one command can be accepted per cycle (shared command bus).
- Counters do not wrap. steps_left saturates at 0. The phase counter reloads per phase.

## Timing
- Accept at edge N. busy, motor_on and motor_dir are updated from N+1.
- First STEP rises at N+1+SETUP_CYC. Each pulse is high for half cycles and low for half cycles.
- The final LOW ends at N+1+SETUP_CYC+2·half·steps. busy falls and done pulses on that edge, for one cycle.
- steps_left decrements on each LOW→HIGH/IDLE edge.
- A new command on the same channel is accepted at the earliest on the cycle busy is low. That gives back-to-back moves with zero idle gap beyond the one accept cycle.
- Abort at edge M: outputs are idle from M+1. A command is accepted no earlier than M+1.
- Reset deassertion mid-move: the channel restarts in IDLE and no pulse is emitted.

## Structure
- Package stepper_pkg: state enum (IDLE, SETUP, HIGH, LOW) and default width constants.
- Sub-module stepper_channel holds one FSM, phase counter and step counter. It is instantiated NUM_CH times via generate.
- The top level does command decode, ready generation and output packing.

## Test plan
- Reset, then ch0 cmd dir=1, steps=3, half=2, SETUP_CYC=4:
  - motor_dir0=1 at N+1.
  - STEP rises at N+5, N+9 and N+13, each 2 cycles high.
  - done0 pulses at N+17; busy0 is high for 16 cycles.
  - steps_left0 goes 3→2→1→0.
- cmd steps=0 → done pulses at N+1. busy, motor_on and motor_step all stay 0.
- Concurrent commands:
  - ch0 half=1 steps=4, ch1 accepted the next cycle with half=3 steps=2: both pulse trains are exact and independent.
  - cmd to busy ch0: cmd_ready=0 and the channel state is unchanged.
- abort0 asserted in HIGH after the 2nd rising edge of a 5-step move → motor_step0=0 and busy0=0 the next cycle. done0 never pulses. steps_left0=4.
- cmd_half=0 behaves identically to cmd_half=1.
- reset asserted low mid-HIGH → all outputs 0 immediately (asynchronously). No STEP after release until a new command.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and default sizing for the multi-channel stepper pulse engine.
package stepper_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow
    } step_state_e;

    localparam int unsigned DefNumCh    = 2;
    localparam int unsigned DefCntW     = 16;
    localparam int unsigned DefDivW     = 18;
    localparam int unsigned DefSetupCyc = 4;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: setup/high/low phase sequencer with a step counter.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned DIV_W     = DefDivW,
    parameter int unsigned SETUP_CYC = DefSetupCyc
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic [DIV_W-1:0] half_i,
    input  logic             abort_i,
    output logic             on_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] steps_left_o
);

    localparam int unsigned SetupW = $clog2(SETUP_CYC) + 1;
    localparam int unsigned PhW    = (DIV_W > SetupW) ? DIV_W : SetupW;

    step_state_e      state_q, state_d;
    logic [PhW-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ph_q    <= '0;
            left_q  <= '0;
            half_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            left_q  <= left_d;
            half_q  <= half_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        left_d  = left_q;
        half_d  = half_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    dir_d  = dir_i;
                    half_d = (half_i == '0) ? DIV_W'(1) : half_i;
                    left_d = steps_i;
                    ph_d   = PhW'(SETUP_CYC - 1);
                    // A zero-length move completes without ever enabling the driver.
                    if (steps_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (ph_q == '0) begin
                    state_d = StHigh;
                    ph_d    = PhW'(half_q) - PhW'(1);
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            StHigh: begin
                if (ph_q == '0) begin
                    state_d = StLow;
                    ph_d    = PhW'(half_q) - PhW'(1);
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            StLow: begin
                if (ph_q == '0) begin
                    left_d = (left_q != '0) ? left_q - CNT_W'(1) : '0;
                    ph_d   = PhW'(half_q) - PhW'(1);
                    if (left_q <= CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StHigh;
                    end
                end else begin
                    ph_d = ph_q - PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any phase transition and keeps the un-decremented count.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            ph_d    = '0;
            left_d  = left_q;
            done_d  = 1'b0;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign on_o         = busy_o;
    assign step_o       = (state_q == StHigh);
    assign dir_o        = dir_q;
    assign done_o       = done_q;
    assign steps_left_o = left_q;

endmodule

// File: rtl/stepper_multi_ctrl.sv
// Multi-channel stepper controller: shared command bus decoded onto NUM_CH channel engines.
module stepper_multi_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned NUM_CH    = DefNumCh,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned DIV_W     = DefDivW,
    parameter int unsigned SETUP_CYC = DefSetupCyc,
    parameter int unsigned CH_W      = ch_width(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_ch,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [DIV_W-1:0]        cmd_half,
    input  logic [NUM_CH-1:0]       abort,
    output logic [NUM_CH-1:0]       motor_on,
    output logic [NUM_CH-1:0]       motor_dir,
    output logic [NUM_CH-1:0]       motor_step,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] steps_left
);

    logic ch_hit;
    logic ch_blocked;

    // Out-of-range channel numbers never match, so they are never ready.
    always_comb begin
        ch_hit     = 1'b0;
        ch_blocked = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cmd_ch == CH_W'(k)) begin
                ch_hit     = 1'b1;
                ch_blocked = busy[k] | abort[k];
            end
        end
    end

    assign cmd_ready = ch_hit & ~ch_blocked;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic start;

        assign start = cmd_valid & cmd_ready & (cmd_ch == CH_W'(k));

        stepper_channel #(
            .CNT_W     (CNT_W),
            .DIV_W     (DIV_W),
            .SETUP_CYC (SETUP_CYC)
        ) u_channel (
            .clk_i        (clock),
            .rst_ni       (reset),
            .start_i      (start),
            .dir_i        (cmd_dir),
            .steps_i      (cmd_steps),
            .half_i       (cmd_half),
            .abort_i      (abort[k]),
            .on_o         (motor_on[k]),
            .dir_o        (motor_dir[k]),
            .step_o       (motor_step[k]),
            .busy_o       (busy[k]),
            .done_o       (done[k]),
            .steps_left_o (steps_left[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_stepper_multi_ctrl.sv
// Scoreboard bench: each command pushes the cycles of its STEP edges, decrements and done pulse.
module tb_stepper_multi_ctrl;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int DIV_W  = 18;
    localparam int SETUP  = 4;
    localparam int CH_W   = 1;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CH_W-1:0]         cmd_ch;
    logic                    cmd_dir;
    logic [CNT_W-1:0]        cmd_steps;
    logic [DIV_W-1:0]        cmd_half;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH-1:0]       motor_on;
    logic [NUM_CH-1:0]       motor_dir;
    logic [NUM_CH-1:0]       motor_step;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH*CNT_W-1:0] steps_left;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_n   = 0;

    int rise_q[NUM_CH][$];
    int fall_q[NUM_CH][$];
    int done_q[NUM_CH][$];
    int dec_cyc_q[NUM_CH][$];
    int dec_val_q[NUM_CH][$];

    logic [NUM_CH-1:0]       prev_step = '0;
    logic [NUM_CH*CNT_W-1:0] prev_left = '0;

    stepper_multi_ctrl #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DIV_W     (DIV_W),
        .SETUP_CYC (SETUP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_half   (cmd_half),
        .abort      (abort),
        .motor_on   (motor_on),
        .motor_dir  (motor_dir),
        .motor_step (motor_step),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int left_of(input int k);
        return int'(steps_left[k*CNT_W +: CNT_W]);
    endfunction

    function automatic int prev_left_of(input int k);
        return int'(prev_left[k*CNT_W +: CNT_W]);
    endfunction

    task automatic push_exp(input int ch, input int n, input int steps, input int h);
        int r;
        for (int i = 0; i < steps; i++) begin
            r = n + 1 + SETUP + 2 * h * i;
            rise_q[ch].push_back(r);
            fall_q[ch].push_back(r + h);
            dec_cyc_q[ch].push_back(r + 2 * h);
            dec_val_q[ch].push_back(steps - 1 - i);
        end
        done_q[ch].push_back((steps == 0) ? n + 1 : n + 1 + SETUP + 2 * h * steps);
    endtask

    // Called at #1 after a posedge; returns at #1 after the following posedge.
    task automatic send(input int ch, input bit dir, input int steps, input int half,
                        input bit push);
        cmd_valid = 1'b1;
        cmd_ch    = CH_W'(ch);
        cmd_dir   = dir;
        cmd_steps = CNT_W'(steps);
        cmd_half  = DIV_W'(half);
        last_n    = cyc;
        #1;
        check("cmd_ready on idle channel", int'(cmd_ready), 1);
        if (push) push_exp(ch, last_n, steps, (half == 0) ? 1 : half);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("motor_dir after accept", int'(motor_dir[ch]), int'(dir));
        check("busy after accept", int'(busy[ch]), int'(steps != 0));
        check("motor_on after accept", int'(motor_on[ch]), int'(steps != 0));
        check("steps_left after accept", left_of(ch), steps);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy != '0 && t < 500) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("wait for idle within bound", int'(t < 500), 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        int e;
        int ev;
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (motor_step[k] && !prev_step[k]) begin
                    e = -1;
                    if (rise_q[k].size() > 0) e = rise_q[k].pop_front();
                    check($sformatf("ch%0d step rise cycle", k), cyc, e);
                end
                if (!motor_step[k] && prev_step[k]) begin
                    e = -1;
                    if (fall_q[k].size() > 0) e = fall_q[k].pop_front();
                    check($sformatf("ch%0d step fall cycle", k), cyc, e);
                end
                if (done[k]) begin
                    e = -1;
                    if (done_q[k].size() > 0) e = done_q[k].pop_front();
                    check($sformatf("ch%0d done cycle", k), cyc, e);
                end
                if (left_of(k) < prev_left_of(k)) begin
                    e  = -1;
                    ev = -1;
                    if (dec_cyc_q[k].size() > 0) begin
                        e  = dec_cyc_q[k].pop_front();
                        ev = dec_val_q[k].pop_front();
                    end
                    check($sformatf("ch%0d decrement cycle", k), cyc, e);
                    check($sformatf("ch%0d decrement value", k), left_of(k), ev);
                end
            end
        end
        prev_step <= motor_step;
        prev_left <= steps_left;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int n;
        int pending;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        cmd_half  = '0;
        abort     = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset motor_on", int'(motor_on), 0);
        check("reset motor_step", int'(motor_step), 0);
        check("reset motor_dir", int'(motor_dir), 0);
        check("reset done", int'(done), 0);
        check("reset steps_left", int'(steps_left), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post-reset busy", int'(busy), 0);

        // Basic 3-step move on ch0
        send(0, 1'b1, 3, 2, 1'b1);
        nb = 0;
        while (busy[0] && nb < 200) begin
            nb++;
            @(posedge clock);
            #1;
        end
        check("ch0 busy length", nb, 16);
        repeat (3) @(posedge clock);
        #1;

        // Zero-step move completes immediately
        send(1, 1'b1, 0, 5, 1'b1);
        check("zero-step motor_step", int'(motor_step[1]), 0);
        repeat (3) @(posedge clock);
        #1;

        // Concurrent moves, then a rejected command to busy ch0
        send(0, 1'b0, 4, 1, 1'b1);
        send(1, 1'b1, 2, 3, 1'b1);
        cmd_valid = 1'b1;
        cmd_ch    = '0;
        cmd_dir   = 1'b1;
        cmd_steps = CNT_W'(9);
        cmd_half  = DIV_W'(7);
        #1;
        check("cmd_ready to busy ch0", int'(cmd_ready), 0);
        check("ch0 steps_left during reject", left_of(0), 4);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("ch0 dir unchanged by reject", int'(motor_dir[0]), 0);
        check("ch0 still busy after reject", int'(busy[0]), 1);
        wait_idle();

        // half = 0 behaves as half = 1
        send(0, 1'b1, 2, 0, 1'b1);
        wait_idle();

        // Abort in HIGH after the second rising edge of a 5-step move
        send(0, 1'b0, 5, 3, 1'b0);
        n = last_n;
        rise_q[0].push_back(n + 5);
        rise_q[0].push_back(n + 11);
        fall_q[0].push_back(n + 8);
        dec_cyc_q[0].push_back(n + 11);
        dec_val_q[0].push_back(4);
        repeat (11) @(posedge clock);
        #1;
        check("ch0 high before abort", int'(motor_step[0]), 1);
        abort = 2'b01;
        fall_q[0].push_back(n + 13);
        @(posedge clock);
        #1;
        abort = '0;
        check("abort motor_step", int'(motor_step[0]), 0);
        check("abort busy", int'(busy[0]), 0);
        check("abort motor_on", int'(motor_on[0]), 0);
        check("abort steps_left", left_of(0), 4);
        repeat (10) @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a HIGH phase on ch1
        send(1, 1'b1, 3, 4, 1'b0);
        n = last_n;
        rise_q[1].push_back(n + 5);
        repeat (5) @(posedge clock);
        #1;
        check("ch1 high before reset", int'(motor_step[1]), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset motor_step", int'(motor_step), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset motor_on", int'(motor_on), 0);
        check("async reset motor_dir", int'(motor_dir), 0);
        check("async reset steps_left", int'(steps_left), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("after reset release busy", int'(busy), 0);
        check("after reset release step", int'(motor_step), 0);

        pending = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            pending += rise_q[k].size() + fall_q[k].size() + done_q[k].size()
                     + dec_cyc_q[k].size();
        end
        check("pending expectations", pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
